instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
Fetch-control stage that sits directly downstream of the R7 program counter. It drives the counter's PCen/wren/data inputs, reads the instruction memory at the current PC, latches the instruction into IR, and hands it to the execute stage over a valid/ready handshake. A taken branch reported by execute reloads the counter through wren/data before the next fetch.

Parameters:
ADDR_W, 6, PC / instruction-memory address width; must match counter width.
INSTR_W, 9, instruction word width.
MEM_LATENCY, 1, synchronous memory read latency in cycles, legal range 1..3.

Ports:
Clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
run  in  1  fetch enable; sampled in IDLE and at each handshake.
PC  in  ADDR_W  current program counter value from the counter.
PCen  out  1  increment request to the counter.
wren  out  1  load request to the counter.
data  out  ADDR_W  load value to the counter (branch target).
mem_addr  out  ADDR_W  instruction memory address.
mem_rden  out  1  instruction memory read strobe.
mem_q  in  INSTR_W  instruction memory read data.
IR  out  INSTR_W  latched instruction.
ir_valid  out  1  IR holds an unconsumed instruction.
ir_ready  in  1  execute stage accepts IR this cycle.
branch_req  in  1  execute requests a PC load; qualified by handshake.
branch_target  in  ADDR_W  branch destination.

Behaviour:
- FSM states: IDLE, REQ, WAIT, CAP, HOLD. Registered state; async reset to IDLE.
- Reset values: IR=0, ir_valid=0, mem_rden=0, mem_addr=0, PCen=0, wren=0, data=0, wait counter=0.
- IDLE: all strobes low. run=1 -> REQ next edge.
- REQ (1 cycle): mem_addr=PC, mem_rden=1. Load wait counter with MEM_LATENCY-1. Next: WAIT if MEM_LATENCY>1, else CAP.
- WAIT: mem_addr is held and mem_rden=0. Decrement the counter each cycle; when it reaches 1 -> CAP. Dwell is exactly MEM_LATENCY-1 cycles.
- CAP (1 cycle): mem_q is valid. PCen=1 (Moore). At the closing edge: IR<=mem_q, ir_valid<=1, and the counter increments on the same edge. Next: HOLD.
- Fetch latency: REQ to IR valid is MEM_LATENCY+1 edges. For MEM_LATENCY=1 the throughput is 1 instruction per 3 cycles plus the handshake wait.
- HOLD: ir_valid=1, IR stable. Wait for ir_ready.
  - Handshake edge (ir_valid & ir_ready): ir_valid<=0.
  - wren = HOLD & ir_ready & branch_req, combinational. data = branch_target, driven combinationally whenever wren=1, else held 0.
  - After the handshake, next state is REQ if run=1, else IDLE.
  - A branch load lands on the handshake edge, so the following REQ uses the new PC.
- PCen and wren are never high in the same cycle (distinct states). PCen is high only in CAP and is a single-cycle pulse per fetch.
- branch_req without ir_ready, or outside HOLD, is ignored.
- run deasserted mid-fetch: the current fetch completes and waits for its handshake, then goes to IDLE. IR is never abandoned.
- PC wrap: the counter wraps from 2^ADDR_W-1 to 0; no special handling. A fetch at the top address proceeds normally and the next fetch uses address 0.
- Reset mid-operation (any state): immediate return to IDLE, pending IR discarded, all strobes low while reset is high. The controller never asserts PCen or wren during reset.
- Width rule: data and mem_addr are exactly ADDR_W bits, with no extension or truncation.

Test Plan:
- Reset then run=1, MEM_LATENCY=1, mem returns 9'h0A5 at PC=0, ir_ready=1 -> mem_rden at PC=0. CAP asserts PCen one cycle. IR=0x0A5, ir_valid=1 on the next edge. PC becomes 1.
- ir_ready held 0 for 5 cycles with IR=0x123 -> IR and ir_valid stable, no PCen, no REQ. On the ready cycle ir_valid drops and REQ issues at PC+1.
- Handshake with branch_req=1, branch_target=6'd40 -> wren=1 and data=40 for exactly that cycle. The next REQ drives mem_addr=40.
- MEM_LATENCY=3 -> exactly 2 WAIT cycles between REQ and CAP. IR captures mem_q presented 3 edges after REQ.
- PC=63, sequential fetch -> PCen pulse, counter wraps, next mem_addr=0.
- reset asserted asynchronously during WAIT and during HOLD -> state IDLE, ir_valid=0, IR=0, PCen=wren=mem_rden=0 before the next edge. Fetch resumes from the current PC after release with run=1.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Fetch control between the R7 program counter and instruction memory:
// issues reads at PC, captures IR, steps or loads the counter, and hands IR to execute.
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned INSTR_W     = 9,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               run,
  input  logic [ADDR_W-1:0]  PC,
  output logic               PCen,
  output logic               wren,
  output logic [ADDR_W-1:0]  data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rden,
  input  logic [INSTR_W-1:0] mem_q,
  output logic [INSTR_W-1:0] IR,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target
);

  localparam int unsigned CNT_W = 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;

  // State and wait counter registers
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic; WAIT dwells MEM_LATENCY-1 cycles
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: if (run) state_nxt = REQ;
      REQ: begin
        wait_cnt_nxt = CNT_W'(MEM_LATENCY - 1);
        state_nxt    = (MEM_LATENCY > 1) ? WAIT : CAP;
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - CNT_W'(1);
        if (wait_cnt == CNT_W'(1)) state_nxt = CAP;
      end
      CAP:  state_nxt = HOLD;
      HOLD: if (ir_ready) state_nxt = run ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch address held through WAIT; instruction register and its valid flag
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      if (state == REQ) addr_q <= PC;
      if (state == CAP) begin
        ir_q       <= mem_q;
        ir_valid_q <= 1'b1;
      end else if (state == HOLD && ir_ready) begin
        ir_valid_q <= 1'b0;
      end
    end
  end

  // PC must be seen in the REQ cycle itself since the counter updates on the edge entering REQ
  assign mem_addr = (state == REQ) ? PC : addr_q;
  assign mem_rden = (state == REQ);
  assign PCen     = (state == CAP);
  assign wren     = (state == HOLD) && ir_ready && branch_req;
  assign data     = wren ? branch_target : '0;
  assign IR       = ir_q;
  assign ir_valid = ir_valid_q;

endmodule
